// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester, memory and status signals of the two-port memory arbiter
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          IReq;
    logic [AW-1:0] IAddr;
    logic          IAck;
    logic [DW-1:0] IRData;
    logic          DReq;
    logic          DWe;
    logic [AW-1:0] DAddr;
    logic [DW-1:0] DWData;
    logic          DAck;
    logic [DW-1:0] DRData;
    logic [AW-1:0] MemAddress;
    logic [DW-1:0] MemWriteData;
    logic          MemRead;
    logic          MemWrite;
    logic [DW-1:0] MemReadData;
    logic          Busy;

    modport slave (
        input  IReq, IAddr, DReq, DWe, DAddr, DWData, MemReadData,
        output IAck, IRData, DAck, DRData, MemAddress, MemWriteData, MemRead, MemWrite, Busy
    );

    modport master (
        output IReq, IAddr, DReq, DWe, DAddr, DWData, MemReadData,
        input  IAck, IRData, DAck, DRData, MemAddress, MemWriteData, MemRead, MemWrite, Busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for a single-port synchronous memory
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 2,
    parameter int AW           = 32,
    parameter int DW           = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t        state_q, state_d;
    logic          owner_q, owner_d;     // 1 = data port owns the current access
    logic          we_q, we_d;
    logic [3:0]    starve_q, starve_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          mem_read_q, mem_read_d;
    logic          mem_write_q, mem_write_d;
    logic          iack_q, iack_d;
    logic          dack_q, dack_d;
    logic [DW-1:0] irdata_q, irdata_d;
    logic [DW-1:0] drdata_q, drdata_d;
    logic          busy_q, busy_d;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        starve_d    = starve_q;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        iack_d      = 1'b0;
        dack_d      = 1'b0;
        irdata_d    = irdata_q;
        drdata_d    = drdata_q;
        busy_d      = busy_q;

        // Outputs are registered, so each state computes what the next state drives.
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.IReq || bus.DReq) begin
                    state_d = ISSUE;
                    busy_d  = 1'b1;
                    if (bus.DReq && (!bus.IReq || (starve_q < LIMIT))) begin
                        owner_d     = 1'b1;
                        we_d        = bus.DWe;
                        starve_d    = bus.IReq ? starve_q + 4'd1 : 4'd0;
                        mem_addr_d  = bus.DAddr;
                        mem_wdata_d = bus.DWe ? bus.DWData : '0;
                        mem_read_d  = !bus.DWe;
                        mem_write_d = bus.DWe;
                    end else begin
                        owner_d    = 1'b0;
                        we_d       = 1'b0;
                        starve_d   = 4'd0;
                        mem_addr_d = bus.IAddr;
                        mem_read_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
                busy_d  = 1'b1;
            end
            CAPTURE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                if (owner_q) begin
                    dack_d   = 1'b1;
                    drdata_d = we_q ? '0 : bus.MemReadData;
                end else begin
                    iack_d   = 1'b1;
                    irdata_d = bus.MemReadData;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            starve_q    <= 4'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            iack_q      <= 1'b0;
            dack_q      <= 1'b0;
            irdata_q    <= '0;
            drdata_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            starve_q    <= starve_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            iack_q      <= iack_d;
            dack_q      <= dack_d;
            irdata_q    <= irdata_d;
            drdata_q    <= drdata_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.MemAddress   = mem_addr_q;
    assign bus.MemWriteData = mem_wdata_q;
    assign bus.MemRead      = mem_read_q;
    assign bus.MemWrite     = mem_write_q;
    assign bus.IAck         = iack_q;
    assign bus.IRData       = irdata_q;
    assign bus.DAck         = dack_q;
    assign bus.DRData       = drdata_q;
    assign bus.Busy         = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
    logic clk;
    logic reset;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(.STARVE_LIMIT(2), .AW(32), .DW(32)) dut (
        .Clk   (clk),
        .Reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:63];
    logic [31:0] mem_rdata;

    always @(posedge clk) begin
        if (bus.MemWrite) mem[bus.MemAddress[7:2]] <= bus.MemWriteData;
        if (bus.MemRead)  mem_rdata <= mem[bus.MemAddress[7:2]];
    end
    assign bus.MemReadData = mem_rdata;

    typedef struct {
        logic        is_d;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic is_d, input logic [31:0] data);
        exp_t e;
        e.is_d = is_d;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (bus.IAck || bus.DAck) begin
            chk("single_ack", {62'd0, bus.IAck, bus.DAck} == 64'd3, 64'd0);
            chk("ack_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("ack_port", 64'(bus.DAck), 64'(e.is_d));
                chk("ack_data", 64'(bus.DAck ? bus.DRData : bus.IRData), 64'(e.data));
            end
        end
    endtask

    initial begin
        logic any_active;
        int   acks;

        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[1]    = 32'h8C010008;
        mem[3]    = 32'h11112222;
        mem_rdata = 32'h0;
        bus.IReq = 1'b0; bus.IAddr = '0;
        bus.DReq = 1'b0; bus.DWe = 1'b0; bus.DAddr = '0; bus.DWData = '0;

        // reset then idle
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_busy", 64'(bus.Busy), 64'd0);
        chk("rst_outs", {bus.MemAddress, bus.MemWriteData} | 64'({bus.IRData, bus.DRData} != 64'd0), 64'd0);
        any_active = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            any_active |= bus.MemRead | bus.MemWrite | bus.Busy | bus.IAck | bus.DAck;
        end
        chk("idle_quiet", 64'(any_active), 64'd0);

        // single fetch
        bus.IReq = 1'b1; bus.IAddr = 32'h4;
        push_exp(1'b0, 32'h8C010008);
        tick();
        chk("fetch_memread", 64'(bus.MemRead), 64'd1);
        chk("fetch_addr", 64'(bus.MemAddress), 64'h4);
        chk("fetch_busy", 64'(bus.Busy), 64'd1);
        tick();
        chk("fetch_capture_rd", 64'(bus.MemRead), 64'd0);
        tick();
        chk("fetch_iack", 64'(bus.IAck), 64'd1);
        chk("fetch_dack", 64'(bus.DAck), 64'd0);
        chk("fetch_idle_busy", 64'(bus.Busy), 64'd0);
        bus.IReq = 1'b0;

        // store then load
        bus.DReq = 1'b1; bus.DWe = 1'b1; bus.DAddr = 32'h8; bus.DWData = 32'hDEADBEEF;
        push_exp(1'b1, 32'h0);
        tick();
        chk("store_memwrite", 64'(bus.MemWrite), 64'd1);
        chk("store_memread", 64'(bus.MemRead), 64'd0);
        chk("store_wdata", 64'(bus.MemWriteData), 64'hDEADBEEF);
        tick();
        chk("store_wdata_cleared", 64'(bus.MemWriteData), 64'd0);
        tick();
        chk("store_dack", 64'(bus.DAck), 64'd1);
        chk("store_mem", 64'(mem[2]), 64'hDEADBEEF);
        bus.DWe = 1'b0;
        push_exp(1'b1, 32'hDEADBEEF);
        tick();
        chk("load_memread", 64'(bus.MemRead), 64'd1);
        tick();
        tick();
        chk("load_dack", 64'(bus.DAck), 64'd1);
        chk("irdata_hold", 64'(bus.IRData), 64'h8C010008);
        bus.DReq = 1'b0;
        tick();
        chk("sb_empty_basic", 64'(exp_q.size()), 64'd0);

        // contention: grant order D, D, I repeating
        bus.IReq = 1'b1; bus.IAddr = 32'h4;
        bus.DReq = 1'b1; bus.DWe = 1'b0; bus.DAddr = 32'hC;
        for (int r = 0; r < 2; r++) begin
            push_exp(1'b1, 32'h11112222);
            push_exp(1'b1, 32'h11112222);
            push_exp(1'b0, 32'h8C010008);
        end
        acks = 0;
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (bus.IAck || bus.DAck) acks++;
            if (k % 3 == 0) chk("cont_ack_cycle", 64'(bus.IAck | bus.DAck), 64'd1);
        end
        bus.IReq = 1'b0; bus.DReq = 1'b0;
        chk("cont_ack_count", 64'(acks), 64'd6);
        chk("sb_empty_cont", 64'(exp_q.size()), 64'd0);
        tick();
        tick();

        // reset during a load's issue cycle
        bus.DReq = 1'b1; bus.DWe = 1'b0; bus.DAddr = 32'hC;
        tick();
        chk("rl_issue", 64'(bus.MemRead), 64'd1);
        reset = 1'b1; bus.DReq = 1'b0;
        tick();
        reset = 1'b0;
        chk("rl_busy", 64'(bus.Busy), 64'd0);
        chk("rl_drdata_cleared", 64'(bus.DRData), 64'd0);
        chk("rl_memread", 64'(bus.MemRead), 64'd0);
        for (int i = 0; i < 4; i++) tick();
        bus.DReq = 1'b1;
        push_exp(1'b1, 32'h11112222);
        tick();
        tick();
        tick();
        chk("rl_reissue_dack", 64'(bus.DAck), 64'd1);
        bus.DReq = 1'b0;

        // reset during a store's issue cycle
        bus.DReq = 1'b1; bus.DWe = 1'b1; bus.DAddr = 32'h10; bus.DWData = 32'hCAFEF00D;
        tick();
        chk("rs_issue", 64'(bus.MemWrite), 64'd1);
        reset = 1'b1; bus.DReq = 1'b0;
        tick();
        reset = 1'b0;
        chk("rs_busy", 64'(bus.Busy), 64'd0);
        for (int i = 0; i < 4; i++) tick();
        chk("rs_mem_written", 64'(mem[4]), 64'hCAFEF00D);
        bus.DReq = 1'b1; bus.DWe = 1'b0;
        push_exp(1'b1, 32'hCAFEF00D);
        tick();
        tick();
        tick();
        chk("rs_readback_dack", 64'(bus.DAck), 64'd1);
        bus.DReq = 1'b0;
        tick();
        chk("sb_empty_final", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
